// File: rtl/divider_seq_param_if.sv
// Request/result bundle for divider_seq_param.
// The master drives operands and start; the slave returns the registered results.
interface divider_seq_param_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic         is_signed;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         busy;
  logic         valid;
  logic         error;
  logic         ovf;

  modport master (
    output start, is_signed, a, b,
    input  q, r, busy, valid, error, ovf
  );

  modport slave (
    input  start, is_signed, a, b,
    output q, r, busy, valid, error, ovf
  );
endinterface

// File: rtl/divider_seq_param.sv
// Sequential restoring divider, N-bit signed/unsigned, one quotient bit per cycle.
// Define DIVSEQ_OVF_DETECT_EN to saturate and flag -2^(N-1) / -1; otherwise q wraps.
module divider_seq_param #(
  parameter int unsigned N = 8
) (
  input  logic               clk,
  input  logic               rst,
  divider_seq_param_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [5:0] CNT_LAST   = 6'(N);
  localparam logic [5:0] CNT_PENULT = 6'(N - 1);

  state_t       state_q;
  logic [5:0]   cnt_q;
  logic [N-1:0] acc_q;
  logic [N-1:0] rem_q;
  logic [N-1:0] dmag_q;
  logic [N-1:0] q_q;
  logic [N-1:0] r_q;
  logic         qneg_q;
  logic         rneg_q;
  logic         dz_q;
  logic         busy_q;
  logic         valid_q;
  logic         error_q;
`ifdef DIVSEQ_OVF_DETECT_EN
  logic         sgn_q;
  logic         ovf_q;
  logic         ovf_hit;
`endif

  logic         b_zero;
  logic [N-1:0] a_mag;
  logic [N-1:0] b_mag;
  logic [N:0]   rem_sh;
  logic [N:0]   trial;
  logic [N-1:0] q_fin;
  logic [N-1:0] r_fin;

  always_comb begin
    b_zero = (bus.b == '0);
    a_mag  = (bus.is_signed && bus.a[N-1]) ? -bus.a : bus.a;
    b_mag  = (bus.is_signed && bus.b[N-1]) ? -bus.b : bus.b;
    rem_sh = {rem_q, acc_q[N-1]};
    trial  = rem_sh - {1'b0, dmag_q};
    q_fin  = qneg_q ? -acc_q : acc_q;
    r_fin  = rneg_q ? -rem_q : rem_q;
`ifdef DIVSEQ_OVF_DETECT_EN
    // A non-negative signed quotient with its top bit set only arises from -2^(N-1) / -1.
    ovf_hit = sgn_q & ~qneg_q & acc_q[N-1];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      dmag_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
`ifdef DIVSEQ_OVF_DETECT_EN
      sgn_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            // Zero divisor parks the raw dividend in rem_q and skips straight to the last count,
            // so the error result lands one edge after start without iterating.
            acc_q   <= a_mag;
            rem_q   <= b_zero ? bus.a : '0;
            dmag_q  <= b_mag;
            qneg_q  <= bus.is_signed & (bus.a[N-1] ^ bus.b[N-1]);
            rneg_q  <= bus.is_signed & bus.a[N-1] & ~b_zero;
            dz_q    <= b_zero;
            cnt_q   <= b_zero ? CNT_LAST : '0;
            busy_q  <= ~b_zero;
            error_q <= 1'b0;
`ifdef DIVSEQ_OVF_DETECT_EN
            sgn_q   <= bus.is_signed;
            ovf_q   <= 1'b0;
`endif
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          if (cnt_q == CNT_LAST) begin
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
            if (dz_q) begin
              q_q     <= '1;
              r_q     <= r_fin;
              error_q <= 1'b1;
            end else begin
              q_q <= q_fin;
              r_q <= r_fin;
`ifdef DIVSEQ_OVF_DETECT_EN
              if (ovf_hit) begin
                q_q   <= {1'b0, {(N-1){1'b1}}};
                ovf_q <= 1'b1;
              end
`endif
            end
          end else begin
            rem_q <= trial[N] ? rem_sh[N-1:0] : trial[N-1:0];
            acc_q <= {acc_q[N-2:0], ~trial[N]};
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == CNT_PENULT) begin
              busy_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.q     = q_q;
  assign bus.r     = r_q;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.error = error_q;
`ifdef DIVSEQ_OVF_DETECT_EN
  assign bus.ovf   = ovf_q;
`else
  assign bus.ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_divider_seq_param.sv
// Scoreboard bench for divider_seq_param: N=8 directed cases plus N=5/N=8 random regression.
module tb_divider_seq_param;

  typedef struct {
    int unsigned q;
    int unsigned r;
    bit          err;
    bit          ovf;
    int unsigned due;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  int unsigned cyc   = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb8[$];
  exp_t        sb5[$];
  exp_t        m8;
  exp_t        m5;

  divider_seq_param_if #(.N(8)) i8 ();
  divider_seq_param_if #(.N(5)) i5 ();

  divider_seq_param #(.N(8)) u_dut8 (.clk(clk), .rst(rst_n), .bus(i8));
  divider_seq_param #(.N(5)) u_dut5 (.clk(clk), .rst(rst_n), .bus(i5));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int unsigned q, input int unsigned r, input bit err, input bit ovf);
    exp_t e;
    e.q = q; e.r = r; e.err = err; e.ovf = ovf; e.due = 0;
    return e;
  endfunction

  // Reference: native integer division truncates toward zero, % follows the dividend's sign.
  function automatic exp_t model(input int n, input bit sgn, input int unsigned a, input int unsigned b);
    exp_t        e;
    int unsigned mask;
    int          sa;
    int          sd;
    mask = (32'd1 << n) - 1;
    e = mk(0, 0, 0, 0);
    if (b == 0) begin
      e.q = mask; e.r = a & mask; e.err = 1'b1;
    end else if (sgn) begin
      sa = a[n-1] ? int'(a) - (1 << n) : int'(a);
      sd = b[n-1] ? int'(b) - (1 << n) : int'(b);
      if (sa == -(1 << (n-1)) && sd == -1) begin
`ifdef DIVSEQ_OVF_DETECT_EN
        e.q = mask >> 1; e.ovf = 1'b1;
`else
        e.q = 32'd1 << (n-1);
`endif
        e.r = 0;
      end else begin
        e.q = $unsigned(sa / sd) & mask;
        e.r = $unsigned(sa % sd) & mask;
      end
    end else begin
      e.q = a / b; e.r = a % b;
    end
    return e;
  endfunction

  function automatic int pending(input int n);
    return (n == 8) ? sb8.size() : sb5.size();
  endfunction

  task automatic wait_idle(input int n);
    for (int i = 0; i < 40; i++) begin
      if (pending(n) == 0) break;
      @(negedge clk);
    end
    if (pending(n) != 0) begin
      check("result_timeout", pending(n), 0);
      if (n == 8) sb8.delete(); else sb5.delete();
    end
  endtask

  // Called at a negedge; start is sampled on the following rising edge.
  task automatic issue(input int n, input bit sgn, input int unsigned a, input int unsigned b,
                       input exp_t e, input bit wt);
    e.due = cyc + 1 + ((b == 0) ? 1 : n + 1);
    if (n == 8) begin
      i8.start = 1'b1; i8.is_signed = sgn; i8.a = a[7:0]; i8.b = b[7:0];
      sb8.push_back(e);
    end else begin
      i5.start = 1'b1; i5.is_signed = sgn; i5.a = a[4:0]; i5.b = b[4:0];
      sb5.push_back(e);
    end
    @(negedge clk);
    i8.start = 1'b0;
    i5.start = 1'b0;
    if (wt) wait_idle(n);
  endtask

  always @(negedge clk) begin
    if (i8.valid === 1'b1) begin
      if (sb8.size() == 0) begin
        check("n8_spurious_valid", 1, 0);
      end else begin
        m8 = sb8.pop_front();
        check("n8_q", i8.q, m8.q);
        check("n8_r", i8.r, m8.r);
        check("n8_error", i8.error, m8.err);
        check("n8_ovf", i8.ovf, m8.ovf);
        check("n8_latency", cyc, m8.due);
      end
    end
  end

  always @(negedge clk) begin
    if (i5.valid === 1'b1) begin
      if (sb5.size() == 0) begin
        check("n5_spurious_valid", 1, 0);
      end else begin
        m5 = sb5.pop_front();
        check("n5_q", i5.q, m5.q);
        check("n5_r", i5.r, m5.r);
        check("n5_error", i5.error, m5.err);
        check("n5_ovf", i5.ovf, m5.ovf);
        check("n5_latency", cyc, m5.due);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    int          busy_cnt;
    int unsigned c0;
    int unsigned a;
    int unsigned b;
    int unsigned mask;

    i8.start = 1'b0; i8.is_signed = 1'b0; i8.a = '0; i8.b = '0;
    i5.start = 1'b0; i5.is_signed = 1'b0; i5.a = '0; i5.b = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q", i8.q, 0);
    check("rst_r", i8.r, 0);
    check("rst_busy", i8.busy, 0);
    check("rst_valid", i8.valid, 0);
    check("rst_error", i8.error, 0);
    check("rst_ovf", i8.ovf, 0);
    check("rst_n5_busy", i5.busy, 0);
    rst_n = 1'b1;

    // First start right on the first rising edge after release; count busy cycles.
    issue(8, 1, 13, 2, mk(6, 1, 0, 0), 0);
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i8.busy === 1'b1) busy_cnt++;
      if (sb8.size() == 0) break;
      @(negedge clk);
    end
    check("busy_cycles", busy_cnt, 8);
    wait_idle(8);

    issue(8, 1, 10, 'hFD, mk('hFD, 1, 0, 0), 1);
    issue(8, 1, 'hF9, 2, mk('hFD, 'hFF, 0, 0), 1);
    issue(8, 1, 'hF2, 'hFD, mk(4, 'hFE, 0, 0), 1);
    issue(8, 0, 200, 7, mk(28, 4, 0, 0), 1);
    issue(8, 0, 255, 255, mk(1, 0, 0, 0), 1);
    issue(8, 1, 200, 7, mk('hF8, 0, 0, 0), 1);
    issue(8, 0, 13, 0, mk('hFF, 13, 1, 0), 1);
    issue(8, 1, 0, 2, mk(0, 0, 0, 0), 1);
    issue(8, 1, 'hF3, 0, mk('hFF, 'hF3, 1, 0), 1);
`ifdef DIVSEQ_OVF_DETECT_EN
    issue(8, 1, 'h80, 'hFF, mk('h7F, 0, 0, 1), 1);
`else
    issue(8, 1, 'h80, 'hFF, mk('h80, 0, 0, 0), 1);
`endif
    issue(8, 1, 'h80, 1, mk('h80, 0, 0, 0), 1);

    // Start held high: operands changed mid-CALC must only take effect on the DONE-cycle restart.
    c0 = cyc;
    i8.start = 1'b1; i8.is_signed = 1'b1; i8.a = 8'd10; i8.b = 8'hFD;
    e = mk('hFD, 1, 0, 0);    e.due = c0 + 10; sb8.push_back(e);
    e = mk('hFD, 'hFF, 0, 0); e.due = c0 + 20; sb8.push_back(e);
    @(negedge clk);
    i8.a = 8'hF9; i8.b = 8'd2;
    repeat (10) @(negedge clk);
    i8.start = 1'b0;
    wait_idle(8);

    // Reset in the middle of CALC: outputs clear and the aborted operation never reports.
    issue(8, 0, 200, 7, mk(28, 4, 0, 0), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_q", i8.q, 0);
    check("midrst_r", i8.r, 0);
    check("midrst_busy", i8.busy, 0);
    check("midrst_valid", i8.valid, 0);
    check("midrst_error", i8.error, 0);
    check("midrst_ovf", i8.ovf, 0);
    sb8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("midrst_q_hold", i8.q, 0);

    for (int n = 5; n <= 8; n += 3) begin
      mask = (32'd1 << n) - 1;
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < 500; k++) begin
          a = $urandom() & mask;
          b = ($urandom_range(0, 31) == 0) ? 0 : ($urandom() & mask);
          if ($urandom_range(0, 63) == 0) a = 32'd1 << (n - 1);
          if (a == (32'd1 << (n - 1)) && $urandom_range(0, 1) == 1) b = mask;
          issue(n, s[0], a, b, model(n, s[0], a, b), 1);
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
